// File: rtl/img_template_capture.sv
// Binary 16x16 template capture: each cell is the thresholded mean of a
// 2^HALVING square block from the top-left window of the pixel stream.
module img_template_capture #(
    parameter int unsigned HALVING = 4,
    parameter logic [9:0]  THRESH  = 10'd128,
    parameter logic [9:0]  HI_VAL  = 10'd255,
    parameter logic [9:0]  LO_VAL  = 10'd0
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iSTART,
    input  logic        iDVAL,
    input  logic [12:0] iX,
    input  logic [12:0] iY,
    input  logic [9:0]  iPIX,
    input  logic [7:0]  iRD_ADDR,
    output logic [9:0]  oRD_DATA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [8:0]  oCELLS
);

    localparam int unsigned ACC_W = 10 + 2 * HALVING;
    localparam logic [12:0] WIN   = 13'(16 << HALVING);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       cx;
    logic [3:0]       cy;
    logic             in_win;
    logic             first_px;
    logic             last_px;
    logic             sof;
    logic             take;
    logic             restart;
    logic             wr_en;
    logic [ACC_W-1:0] sum;
    logic [9:0]       mean;
    logic [9:0]       cell_val;
    logic [8:0]       cells_next;
    logic [ACC_W-1:0] acc [16];
    logic [9:0]       mem [256];

    assign cx       = iX[HALVING +: 4];
    assign cy       = iY[HALVING +: 4];
    assign in_win   = (iX < WIN) && (iY < WIN);
    assign first_px = (iX[HALVING-1:0] == '0) && (iY[HALVING-1:0] == '0);
    assign last_px  = (&iX[HALVING-1:0]) && (&iY[HALVING-1:0]);
    assign sof      = iDVAL && (iX == '0) && (iY == '0);

    // Block sum including the closing pixel; mean is its top 10 bits.
    assign sum      = acc[cx] + ACC_W'(iPIX);
    assign mean     = sum[ACC_W-1 -: 10];
    assign cell_val = (mean >= THRESH) ? HI_VAL : LO_VAL;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE:    if (iSTART) state_next = ARM;
            ARM: begin
                if (sof) begin
                    restart    = 1'b1;
                    take       = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                restart = sof;
                take    = iDVAL && in_win;
            end
            DONE:    if (iSTART) state_next = ARM;
            default: state_next = IDLE;
        endcase
        wr_en      = take && last_px;
        cells_next = (restart ? 9'd0 : oCELLS) + {8'd0, wr_en};
        if (state == CAPTURE && cells_next == 9'd256) state_next = DONE;
        oBUSY = (state == ARM) || (state == CAPTURE);
        oDONE = (state == DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oCELLS <= '0;
            for (int unsigned i = 0; i < 16; i++) acc[i] <= '0;
        end else begin
            oCELLS <= cells_next;
            if (take) acc[cx] <= first_px ? ACC_W'(iPIX) : sum;
        end
    end

    // Template storage is deliberately unreset; only the read register clears.
    always_ff @(posedge iCLK) begin
        if (wr_en) mem[{cy, cx}] <= cell_val;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) oRD_DATA <= '0;
        else         oRD_DATA <= mem[iRD_ADDR];
    end

endmodule
